dram_port_arbiter: RTL and testbench
====================================

Name: dram_port_arbiter

Overview:
Two-port access controller in front of the byte-banked data RAM. It arbitrates between the CPU memory stage (port A) and a loader/DMA port (port B), and issues at most one RAM access per cycle. It generates big-endian byte-lane selects and write-data replication, checks alignment, and returns registered, extended load data one cycle after grant.

Parameters:
ADDR_W, 32, byte address width on both ports and on the RAM side.
STARVE_LIMIT, 4, consecutive cycles B may wait while A wins before B is forced to win; range 1..15.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous reset, active-high.
a_req  in  1  A request; held with fields stable until a_gnt.
a_we  in  1  1 = store, 0 = load.
a_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
a_signed  in  1  load sign-extend (1) or zero-extend (0).
a_addr  in  ADDR_W  byte address.
a_wdata  in  32  store data, right-justified.
a_gnt  out  1  combinational; access performed this cycle.
a_rvalid  out  1  registered response pulse, one cycle after a_gnt.
a_rdata  out  32  extended load data; 0 for stores and errors.
a_err  out  1  misaligned or illegal size, valid with a_rvalid.
b_req, b_we, b_size, b_signed, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata, b_err: same as A, for port B.
ram_ce  out  1  RAM chip enable.
ram_we  out  1  RAM write enable.
ram_sel  out  4  byte lanes; sel[3] = bits 31:24 = byte offset 0.
ram_addr  out  ADDR_W  word-aligned address, low 2 bits 0.
ram_wdata  out  32  lane-replicated store data.
ram_rdata  in  32  combinational RAM read data.

Behaviour:
- Reset: rst=1 at a rising edge clears all registers: starve counter 0; a_/b_rvalid, rdata, err = 0. Combinational RAM outputs are 0 whenever no grant occurs. A response pending when reset is applied is discarded and is never delivered.
- Arbitration, combinational each cycle:
  - A alone requests: grant A.
  - B alone requests: grant B.
  - Both request: grant A unless starve_cnt == STARVE_LIMIT, in which case grant B.
  - Exactly one gnt is asserted per cycle at most.
- starve_cnt: increments when b_req=1 and B is not granted. It clears when B is granted or b_req=0. It saturates at STARVE_LIMIT.
- Alignment checks on the granted request:
  - byte: any offset is legal.
  - half: addr[0] must be 0.
  - word: addr[1:0] must be 00.
  - size 11 is always an error.
- Error access: the request is still granted and consumes the slot. ram_ce=0, the RAM is not touched, and the response returns err=1 with rdata=0.
- Legal access, in the grant cycle: ram_ce=1, ram_we=req_we, ram_addr = {addr[ADDR_W-1:2], 2'b00}. With o = addr[1:0]:
  - byte: sel = 4'b1000 >> o; wdata = {4{wdata[7:0]}}.
  - half: sel = 1100 when o=0, 0011 when o=2; wdata = {2{wdata[15:0]}}.
  - word: sel = 1111; wdata passed through unchanged.
- No grant: ram_ce=0, ram_we=0, ram_sel=0, ram_addr=0, ram_wdata=0.
- Load capture: at the edge ending the grant cycle, the granted lane is selected from ram_rdata and registered:
  - byte: ram_rdata[31-8o -: 8].
  - half: ram_rdata[31:16] when o=0, [15:0] when o=2.
  - Result is extended per the signed flag.
  - Store and error responses register rdata=0.
- Response timing: the granted port's rvalid=1 in cycle N+1 for a grant in cycle N, for loads and stores alike. rvalid lasts exactly one cycle. Back-to-back grants give back-to-back rvalid. The other port's rvalid=0.
- Store-then-load to the same word in consecutive cycles returns the new data. The RAM write commits at the grant edge, before the following read.
- A requester may deassert req only after gnt. Deasserting earlier is illegal, and the block need not detect it.

Test Plan:
- Reset then idle: all outputs 0 for 5 cycles. A word store to 0x10 with data 0xDEADBEEF: same cycle a_gnt=1, ram_sel=1111, ram_addr=0x10; next cycle a_rvalid=1, a_rdata=0, a_err=0.
- Byte lanes: store byte 0xA5 at 0x13 gives ram_sel=0001 and ram_wdata=0xA5A5A5A5. With word 0x80FF7F01 at 0x20:
  - signed byte load at 0x20 returns 0xFFFFFF80.
  - unsigned byte load at 0x21 returns 0x000000FF.
  - signed half load at 0x22 returns 0x00007F01.
- Misalignment: half load at 0x21, word store at 0x22, and size 11 each give gnt=1 with ram_ce=0, then rvalid=1, err=1, rdata=0. The RAM word at 0x20 is unchanged.
- Contention with STARVE_LIMIT=4, a_req and b_req held high continuously: grants run A,A,A,A,B and the pattern repeats. starve_cnt returns to 0 after each B grant.
- Reset mid-operation: assert rst in the cycle after an A load grant. a_rvalid stays 0, all outputs are 0, and the next request is served normally.
- Back-to-back: B stores 0x12345678 to 0x40, then loads word 0x40 in the next cycle. Two consecutive b_rvalid pulses; the second returns 0x12345678.

Source files
------------

// File: rtl/dram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dram_port_arbiter
// Purpose  : Two-port access controller in front of a byte-banked data RAM.
//            Arbitrates between the CPU memory stage (port A) and a loader/DMA
//            port (port B), issues at most one RAM access per cycle, generates
//            big-endian byte-lane selects and write-data replication, checks
//            alignment and returns registered, extended load data one cycle
//            after the grant.
// Ports    : clk, rst                   - clock, synchronous active-high reset
//            a_* / b_*                  - request (req, we, size, signed, addr,
//                                         wdata) and response (gnt, rvalid,
//                                         rdata, err) for each port
//            ram_ce/we/sel/addr/wdata   - combinational RAM command
//            ram_rdata                  - combinational RAM read data
// Revision : 1.0 - initial release
// ============================================================================
module dram_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    // Port A (CPU memory stage)
    input  logic              a_req,
    input  logic              a_we,
    input  logic [1:0]        a_size,
    input  logic              a_signed,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [31:0]       a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [31:0]       a_rdata,
    output logic              a_err,
    // Port B (loader / DMA)
    input  logic              b_req,
    input  logic              b_we,
    input  logic [1:0]        b_size,
    input  logic              b_signed,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [31:0]       b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [31:0]       b_rdata,
    output logic              b_err,
    // RAM side
    output logic              ram_ce,
    output logic              ram_we,
    output logic [3:0]        ram_sel,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

    logic [3:0]        r_starve_cnt;
    logic              r_a_rvalid, r_a_err, r_b_rvalid, r_b_err;
    logic [31:0]       r_a_rdata, r_b_rdata;

    logic              w_a_gnt, w_b_gnt, w_gnt;
    logic              w_we, w_signed, w_err, w_legal;
    logic [1:0]        w_size, w_off;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_wd;
    logic [3:0]        w_sel;
    logic [31:0]       w_wdata;
    logic [7:0]        w_lane_byte;
    logic [15:0]       w_lane_half;
    logic [31:0]       w_ext;
    logic [31:0]       w_load_data;

    // Arbitration: A has priority unless B has waited STARVE_LIMIT cycles.
    // No grant is issued while reset is asserted.
    always_comb begin
        w_a_gnt = 1'b0;
        w_b_gnt = 1'b0;
        if (!rst) begin
            if (a_req && b_req) begin
                if (r_starve_cnt == c_starve_limit) begin
                    w_b_gnt = 1'b1;
                end else begin
                    w_a_gnt = 1'b1;
                end
            end else begin
                w_a_gnt = a_req;
                w_b_gnt = b_req;
            end
        end
    end

    assign w_gnt    = w_a_gnt | w_b_gnt;
    assign w_we     = w_b_gnt ? b_we     : a_we;
    assign w_size   = w_b_gnt ? b_size   : a_size;
    assign w_signed = w_b_gnt ? b_signed : a_signed;
    assign w_addr   = w_b_gnt ? b_addr   : a_addr;
    assign w_wd     = w_b_gnt ? b_wdata  : a_wdata;
    assign w_off    = w_addr[1:0];

    // Illegal size or misalignment still consumes the slot but never
    // touches the RAM.
    always_comb begin
        case (w_size)
            2'd0:    w_err = 1'b0;
            2'd1:    w_err = w_off[0];
            2'd2:    w_err = (w_off != 2'd0);
            default: w_err = 1'b1;
        endcase
    end

    assign w_legal = w_gnt & ~w_err;

    // Big-endian lanes: sel[3] carries byte offset 0 (bits 31:24).
    always_comb begin
        w_sel   = 4'b0000;
        w_wdata = 32'd0;
        case (w_size)
            2'd0: begin
                w_sel   = 4'b1000 >> w_off;
                w_wdata = {4{w_wd[7:0]}};
            end
            2'd1: begin
                w_sel   = w_off[1] ? 4'b0011 : 4'b1100;
                w_wdata = {2{w_wd[15:0]}};
            end
            default: begin
                w_sel   = 4'b1111;
                w_wdata = w_wd;
            end
        endcase
    end

    assign ram_ce    = w_legal;
    assign ram_we    = w_legal & w_we;
    assign ram_sel   = w_legal ? w_sel : 4'b0000;
    assign ram_addr  = w_legal ? {w_addr[ADDR_W-1:2], 2'b00} : '0;
    assign ram_wdata = w_legal ? w_wdata : 32'd0;

    // Lane extraction and extension of the read word.
    always_comb begin
        case (w_off)
            2'd1:    w_lane_byte = ram_rdata[23:16];
            2'd2:    w_lane_byte = ram_rdata[15:8];
            2'd3:    w_lane_byte = ram_rdata[7:0];
            default: w_lane_byte = ram_rdata[31:24];
        endcase
        w_lane_half = w_off[1] ? ram_rdata[15:0] : ram_rdata[31:16];
        case (w_size)
            2'd0:    w_ext = {{24{w_signed & w_lane_byte[7]}}, w_lane_byte};
            2'd1:    w_ext = {{16{w_signed & w_lane_half[15]}}, w_lane_half};
            default: w_ext = ram_rdata;
        endcase
        w_load_data = (w_legal && !w_we) ? w_ext : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= 4'd0;
            r_a_rvalid   <= 1'b0;
            r_a_err      <= 1'b0;
            r_a_rdata    <= 32'd0;
            r_b_rvalid   <= 1'b0;
            r_b_err      <= 1'b0;
            r_b_rdata    <= 32'd0;
        end else begin
            r_a_rvalid <= w_a_gnt;
            r_a_err    <= w_a_gnt & w_err;
            r_a_rdata  <= w_a_gnt ? w_load_data : 32'd0;
            r_b_rvalid <= w_b_gnt;
            r_b_err    <= w_b_gnt & w_err;
            r_b_rdata  <= w_b_gnt ? w_load_data : 32'd0;
            if (b_req && !w_b_gnt) begin
                if (r_starve_cnt != c_starve_limit) begin
                    r_starve_cnt <= r_starve_cnt + 4'd1;
                end
            end else begin
                r_starve_cnt <= 4'd0;
            end
        end
    end

    // Responses are masked while reset is high so a response in flight when
    // reset arrives is never seen.
    assign a_gnt    = w_a_gnt;
    assign b_gnt    = w_b_gnt;
    assign a_rvalid = r_a_rvalid & ~rst;
    assign a_err    = r_a_err & ~rst;
    assign a_rdata  = r_a_rdata & {32{~rst}};
    assign b_rvalid = r_b_rvalid & ~rst;
    assign b_err    = r_b_err & ~rst;
    assign b_rdata  = r_b_rdata & {32{~rst}};

endmodule
`default_nettype wire

// File: tb/tb_dram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dram_port_arbiter
// Purpose  : Self-checking bench for dram_port_arbiter: directed vector
//            table, contention / reset / back-to-back sequences and random
//            two-port traffic against a byte-addressed reference memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dram_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int LIMIT  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we, a_signed, b_req, b_we, b_signed;
    logic [1:0]  a_size, b_size;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic        ram_ce, ram_we;
    logic [3:0]  ram_sel;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    always #5 clk = ~clk;

    dram_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_size(a_size), .a_signed(a_signed),
        .a_addr(a_addr), .a_wdata(a_wdata), .a_gnt(a_gnt), .a_rvalid(a_rvalid),
        .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_size(b_size), .b_signed(b_signed),
        .b_addr(b_addr), .b_wdata(b_wdata), .b_gnt(b_gnt), .b_rvalid(b_rvalid),
        .b_rdata(b_rdata), .b_err(b_err),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_sel(ram_sel), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Byte-banked RAM driven purely by the DUT's RAM command.
    logic [31:0] mem [0:63];
    assign ram_rdata = mem[ram_addr[7:2]];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
        end else if (ram_ce && ram_we) begin
            if (ram_sel[3]) mem[ram_addr[7:2]][31:24] <= ram_wdata[31:24];
            if (ram_sel[2]) mem[ram_addr[7:2]][23:16] <= ram_wdata[23:16];
            if (ram_sel[1]) mem[ram_addr[7:2]][15:8]  <= ram_wdata[15:8];
            if (ram_sel[0]) mem[ram_addr[7:2]][7:0]   <= ram_wdata[7:0];
        end
    end

    // Reference model state: plain byte array, big-endian multi-byte values.
    logic [7:0] smem [0:255];
    int waits;
    int checks = 0;
    int errors = 0;

    logic        cap_ga, cap_gb, cap_ce, cap_a_rvalid, cap_b_rvalid, cap_a_err;
    logic [3:0]  cap_sel;
    logic [31:0] cap_wd, cap_a_rdata, cap_b_rdata;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ce;
        logic [3:0]  sel;
        logic [31:0] ram_wd;
        logic        err;
        logic [31:0] rdata;
    } vec_t;
    vec_t vt [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] shadow_load(input logic [31:0] a, input logic [1:0] sz,
                                                input logic sgn);
        logic [31:0] v;
        logic [7:0]  ix;
        int n;
        n = nbytes(sz);
        v = 32'd0;
        for (int i = 0; i < n; i++) begin
            ix = a[7:0] + 8'(i);
            v  = (v << 8) | 32'(smem[ix]);
        end
        if (sgn && n == 1 && v[7])  v = v | 32'hFFFFFF00;
        if (sgn && n == 2 && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    task automatic shadow_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        logic [7:0] ix;
        int n;
        n = nbytes(sz);
        for (int i = 0; i < n; i++) begin
            ix = a[7:0] + 8'(i);
            smem[ix] = 8'(wd >> (8 * (n - 1 - i)));
        end
    endtask

    task automatic shadow_clear();
        for (int i = 0; i < 256; i++) smem[i] = 8'd0;
    endtask

    // One bus cycle. Entered 1ns after a rising edge with requests already
    // driven; checks the command mid-cycle and the response after the edge.
    task automatic cycle();
        logic        ga, gb, we, sgn, err, e_ce;
        logic [1:0]  sz, o;
        logic [31:0] ad, wd, e_sel, e_wd, e_addr, e_rd;
        #4;
        ga = a_req && !(b_req && waits == LIMIT);
        gb = b_req && !ga;
        chk("a_gnt", 32'(a_gnt), 32'(ga));
        chk("b_gnt", 32'(b_gnt), 32'(gb));
        we  = gb ? b_we     : a_we;
        sz  = gb ? b_size   : a_size;
        sgn = gb ? b_signed : a_signed;
        ad  = gb ? b_addr   : a_addr;
        wd  = gb ? b_wdata  : a_wdata;
        o   = ad[1:0];
        err  = (sz == 2'd3) || (sz == 2'd1 && o[0]) || (sz == 2'd2 && o != 2'd0);
        e_ce = (ga || gb) && !err;
        e_sel = 32'd0; e_wd = 32'd0; e_addr = 32'd0; e_rd = 32'd0;
        if (e_ce) begin
            e_addr = ad & ~32'h3;
            case (sz)
                2'd0: begin e_sel = 32'(1 << (3 - int'(o))); e_wd = 32'(wd[7:0]) * 32'h01010101; end
                2'd1: begin e_sel = (o == 2'd0) ? 32'd12 : 32'd3; e_wd = 32'(wd[15:0]) * 32'h00010001; end
                default: begin e_sel = 32'd15; e_wd = wd; end
            endcase
            if (!we) e_rd = shadow_load(ad, sz, sgn);
        end
        chk("ram_ce",    32'(ram_ce), 32'(e_ce));
        chk("ram_we",    32'(ram_we), 32'(e_ce && we));
        chk("ram_sel",   32'(ram_sel), e_sel);
        chk("ram_addr",  ram_addr, e_addr);
        chk("ram_wdata", ram_wdata, e_wd);
        cap_ga = a_gnt; cap_gb = b_gnt; cap_ce = ram_ce; cap_sel = ram_sel; cap_wd = ram_wdata;
        @(posedge clk); #1;
        if (e_ce && we) shadow_store(ad, sz, wd);
        chk("a_rvalid", 32'(a_rvalid), 32'(ga));
        chk("b_rvalid", 32'(b_rvalid), 32'(gb));
        chk("a_err",    32'(a_err), 32'(ga && err));
        chk("b_err",    32'(b_err), 32'(gb && err));
        chk("a_rdata",  a_rdata, ga ? e_rd : 32'd0);
        chk("b_rdata",  b_rdata, gb ? e_rd : 32'd0);
        cap_a_rvalid = a_rvalid; cap_b_rvalid = b_rvalid; cap_a_err = a_err;
        cap_a_rdata = a_rdata; cap_b_rdata = b_rdata;
        if (b_req && !gb) waits = (waits < LIMIT) ? waits + 1 : LIMIT;
        else              waits = 0;
        if (ga) a_req = 1'b0;
        if (gb) b_req = 1'b0;
    endtask

    task automatic rnd(output logic we, output logic [1:0] sz, output logic sgn,
                       output logic [31:0] ad, output logic [31:0] wd);
        we  = 1'($urandom_range(0, 1));
        sz  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        sgn = 1'($urandom_range(0, 1));
        ad  = 32'($urandom_range(0, 255));
        if ($urandom_range(0, 7) != 0) begin
            if (sz == 2'd1) ad[0]   = 1'b0;
            if (sz == 2'd2) ad[1:0] = 2'b00;
        end
        wd  = $urandom;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_flags"}, 32'({a_gnt, b_gnt, a_rvalid, b_rvalid, a_err, b_err, ram_ce, ram_we}), 32'd0);
        chk({tag, "_a_rdata"}, a_rdata, 32'd0);
        chk({tag, "_b_rdata"}, b_rdata, 32'd0);
        chk({tag, "_ram_cmd"}, 32'(ram_sel) | ram_addr | ram_wdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            we    size  sgn   addr        wdata         ce    sel    ram_wd        err   rdata
        vt[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0, 32'h00000000};
        vt[1]  = '{1'b1, 2'd0, 1'b0, 32'h13, 32'h000000A5, 1'b1, 4'h1, 32'hA5A5A5A5, 1'b0, 32'h00000000};
        vt[2]  = '{1'b1, 2'd2, 1'b0, 32'h20, 32'h80FF7F01, 1'b1, 4'hF, 32'h80FF7F01, 1'b0, 32'h00000000};
        vt[3]  = '{1'b0, 2'd0, 1'b1, 32'h20, 32'h00000000, 1'b1, 4'h8, 32'h00000000, 1'b0, 32'hFFFFFF80};
        vt[4]  = '{1'b0, 2'd0, 1'b0, 32'h21, 32'h00000000, 1'b1, 4'h4, 32'h00000000, 1'b0, 32'h000000FF};
        vt[5]  = '{1'b0, 2'd1, 1'b1, 32'h22, 32'h00000000, 1'b1, 4'h3, 32'h00000000, 1'b0, 32'h00007F01};
        vt[6]  = '{1'b0, 2'd1, 1'b0, 32'h21, 32'h00000000, 1'b0, 4'h0, 32'h00000000, 1'b1, 32'h00000000};
        vt[7]  = '{1'b1, 2'd2, 1'b0, 32'h22, 32'hFFFFFFFF, 1'b0, 4'h0, 32'h00000000, 1'b1, 32'h00000000};
        vt[8]  = '{1'b0, 2'd3, 1'b0, 32'h20, 32'h00000000, 1'b0, 4'h0, 32'h00000000, 1'b1, 32'h00000000};
        vt[9]  = '{1'b0, 2'd2, 1'b0, 32'h20, 32'h00000000, 1'b1, 4'hF, 32'h00000000, 1'b0, 32'h80FF7F01};
        vt[10] = '{1'b0, 2'd1, 1'b0, 32'h20, 32'h00000000, 1'b1, 4'hC, 32'h00000000, 1'b0, 32'h000080FF};
        vt[11] = '{1'b0, 2'd1, 1'b1, 32'h20, 32'h00000000, 1'b1, 4'hC, 32'h00000000, 1'b0, 32'hFFFF80FF};
        vt[12] = '{1'b1, 2'd1, 1'b0, 32'h22, 32'h0000BEEF, 1'b1, 4'h3, 32'hBEEFBEEF, 1'b0, 32'h00000000};
        vt[13] = '{1'b0, 2'd2, 1'b1, 32'h20, 32'h00000000, 1'b1, 4'hF, 32'h00000000, 1'b0, 32'h80FFBEEF};

        rst = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_size = 2'd0; a_signed = 1'b0; a_addr = 32'd0; a_wdata = 32'd0;
        b_req = 1'b0; b_we = 1'b0; b_size = 2'd0; b_signed = 1'b0; b_addr = 32'd0; b_wdata = 32'd0;
        shadow_clear();
        waits = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle after reset: everything quiet.
        repeat (5) cycle();

        // Directed vectors on port A.
        for (int i = 0; i < 14; i++) begin
            a_req = 1'b1; a_we = vt[i].we; a_size = vt[i].size; a_signed = vt[i].sgn;
            a_addr = vt[i].addr; a_wdata = vt[i].wdata;
            cycle();
            chk($sformatf("vec%0d_gnt", i),    32'(cap_ga), 32'd1);
            chk($sformatf("vec%0d_ce", i),     32'(cap_ce), 32'(vt[i].ce));
            chk($sformatf("vec%0d_sel", i),    32'(cap_sel), 32'(vt[i].sel));
            chk($sformatf("vec%0d_wdata", i),  cap_wd, vt[i].ram_wd);
            chk($sformatf("vec%0d_rvalid", i), 32'(cap_a_rvalid), 32'd1);
            chk($sformatf("vec%0d_err", i),    32'(cap_a_err), 32'(vt[i].err));
            chk($sformatf("vec%0d_rdata", i),  cap_a_rdata, vt[i].rdata);
        end

        // Contention: both ports held busy, pattern A,A,A,A,B repeating.
        cycle();
        for (int i = 0; i < 15; i++) begin
            a_req = 1'b1; a_we = 1'b0; a_size = 2'd2; a_addr = 32'h10;
            b_req = 1'b1; b_we = 1'b0; b_size = 2'd2; b_addr = 32'h20;
            cycle();
            chk($sformatf("contend%0d_b_wins", i), 32'(cap_gb), 32'((i % 5) == 4));
        end
        a_req = 1'b0; b_req = 1'b0;
        cycle();

        // Reset in the cycle after an A load grant.
        a_req = 1'b1; a_we = 1'b0; a_size = 2'd2; a_addr = 32'h20;
        #4;
        chk("rst_seq_a_gnt", 32'(a_gnt), 32'd1);
        @(posedge clk);
        rst = 1'b1;
        a_req = 1'b0;
        #1;
        check_all_zero("rst_during");
        @(posedge clk); #1;
        rst = 1'b0;
        shadow_clear();
        waits = 0;
        #1;
        check_all_zero("rst_after");
        a_req = 1'b1; a_we = 1'b1; a_size = 2'd2; a_addr = 32'h30; a_wdata = 32'hCAFEF00D;
        cycle();
        a_req = 1'b1; a_we = 1'b0; a_size = 2'd2; a_signed = 1'b0; a_addr = 32'h30;
        cycle();
        chk("rst_recover_rdata", cap_a_rdata, 32'hCAFEF00D);

        // Back-to-back store then load on port B.
        b_req = 1'b1; b_we = 1'b1; b_size = 2'd2; b_addr = 32'h40; b_wdata = 32'h12345678;
        cycle();
        chk("b2b_rvalid1", 32'(cap_b_rvalid), 32'd1);
        b_req = 1'b1; b_we = 1'b0; b_size = 2'd2; b_signed = 1'b0; b_addr = 32'h40;
        cycle();
        chk("b2b_rvalid2", 32'(cap_b_rvalid), 32'd1);
        chk("b2b_rdata", cap_b_rdata, 32'h12345678);
        cycle();

        // Random two-port traffic; a request is held until granted.
        for (int c = 0; c < 600; c++) begin
            if (!a_req && $urandom_range(0, 3) != 0) begin
                rnd(a_we, a_size, a_signed, a_addr, a_wdata);
                a_req = 1'b1;
            end
            if (!b_req && $urandom_range(0, 3) != 0) begin
                rnd(b_we, b_size, b_signed, b_addr, b_wdata);
                b_req = 1'b1;
            end
            cycle();
        end
        a_req = 1'b0; b_req = 1'b0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
